// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: md_op codes, MDU state encoding and operation latencies shared with the decode controller
package mdu_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;
  typedef enum logic {S_IDLE, S_BUSY} state_e;
  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;
  function automatic logic md_long(input logic [3:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E/D-stage bundle (E_start/E_md_op/E_rs_val/E_rt_val/E_cancel/D_md_use in; busy/D_md_stall/E_md_out/hi/lo out)
interface mdu_ctrl_if;
  logic        E_start;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        E_cancel;
  logic        D_md_use;
  logic        busy;
  logic        D_md_stall;
  logic [31:0] E_md_out;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (
    output E_start, E_md_op, E_rs_val, E_rt_val, E_cancel, D_md_use,
    input  busy, D_md_stall, E_md_out, hi, lo
  );
  modport slave (
    input  E_start, E_md_op, E_rs_val, E_rt_val, E_cancel, D_md_use,
    output busy, D_md_stall, E_md_out, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product/quotient/remainder (op,a,b in; res_hi,res_lo,res_wr out; res_wr=0 on divide by zero)
module md_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);
  logic        sgn;
  logic        is_div;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  always_comb begin
    sgn    = op == OP_MULT || op == OP_DIV;
    is_div = op == OP_DIV || op == OP_DIVU;
    prod   = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
    ua     = sgn && a[31] ? -a : a;
    ub     = sgn && b[31] ? -b : b;
    uq     = ub == 32'd0 ? 32'd0 : ua / ub;
    ur     = ub == 32'd0 ? 32'd0 : ua % ub;
    res_hi = is_div ? (sgn && a[31] ? -ur : ur) : prod[63:32];
    res_lo = is_div ? (sgn && (a[31] ^ b[31]) ? -uq : uq) : prod[31:0];
    res_wr = !(is_div && b == 32'd0);
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer with HI/LO (clk, sync active-high reset, bus slave of mdu_ctrl_if)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);
  state_e      state;
  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;
  logic [31:0] a_hi;
  logic [31:0] a_lo;
  logic        a_wr;
  logic        launch;
  logic        is_mult;
  md_arith u_arith (
    .op     (bus.E_md_op),
    .a      (bus.E_rs_val),
    .b      (bus.E_rt_val),
    .res_hi (a_hi),
    .res_lo (a_lo),
    .res_wr (a_wr)
  );
  assign launch         = bus.E_start & ~bus.E_cancel & ~busy_q;
  assign is_mult        = bus.E_md_op == OP_MULT || bus.E_md_op == OP_MULTU;
  assign bus.busy       = busy_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.E_md_out   = bus.E_md_op == OP_MFHI ? hi_q : bus.E_md_op == OP_MFLO ? lo_q : 32'd0;
  assign bus.D_md_stall = bus.D_md_use & (busy_q | (bus.E_start & md_long(bus.E_md_op)));
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (state == S_IDLE) begin
      if (launch && md_long(bus.E_md_op)) begin
        state   <= S_BUSY;
        busy_q  <= 1'b1;
        cnt     <= is_mult ? MULT_CYC : DIV_CYC;
        pend_hi <= a_hi;
        pend_lo <= a_lo;
        pend_wr <= a_wr;
      end else if (launch && bus.E_md_op == OP_MTHI) begin
        hi_q <= bus.E_rs_val;
      end else if (launch && bus.E_md_op == OP_MTLO) begin
        lo_q <= bus.E_rs_val;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
        if (pend_wr) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven self-checking bench for mdu_ctrl with an expected-result scoreboard
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mdu_ctrl_if bus ();
  mdu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        d_use;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[13];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic cancel, input logic d_use, input logic inj,
                        input exp_t e, input string name);
    int   cyc    = 0;
    int   stalls = 0;
    exp_t got;
    @(negedge clk);
    bus.E_start  = 1'b1;
    bus.E_md_op  = op;
    bus.E_rs_val = rs;
    bus.E_rt_val = rt;
    bus.E_cancel = cancel;
    bus.D_md_use = d_use;
    sb.push_back(e);
    @(negedge clk);
    bus.E_start  = 1'b0;
    bus.E_cancel = 1'b0;
    if (inj) begin
      bus.E_rs_val = 32'hFFFFFFFF;
      bus.E_rt_val = 32'hFFFFFFFF;
    end
    while (bus.busy && cyc < 20) begin
      if (bus.D_md_stall) stalls++;
      cyc++;
      bus.E_start = inj && cyc <= 2;
      @(negedge clk);
    end
    bus.E_start  = 1'b0;
    bus.D_md_use = 1'b0;
    got = sb.pop_front();
    check({name, " busy_cycles"}, 32'(cyc), 32'(got.cyc));
    check({name, " hi"}, bus.hi, got.hi);
    check({name, " lo"}, bus.lo, got.lo);
    if (d_use) check({name, " stall_cycles"}, 32'(stalls), 32'(got.cyc));
  endtask
  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{OP_MTHI,  32'h12345678, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vecs[5]  = '{OP_MTHI,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[6]  = '{OP_MTLO,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'h12345678, 32'hCAFEF00D, 0};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 10};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h40000000, 32'h00000000, 5};
    vecs[10] = '{4'd9,     32'h55555555, 32'h1,        1'b0, 1'b0, 32'h40000000, 32'h00000000, 0};
    vecs[11] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[12] = '{OP_MULT,  32'h00000003, 32'hFFFFFFFB, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    reset        = 1'b1;
    bus.E_start  = 1'b0;
    bus.E_md_op  = OP_NONE;
    bus.E_rs_val = 32'd0;
    bus.E_rt_val = 32'd0;
    bus.E_cancel = 1'b0;
    bus.D_md_use = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset stall", {31'd0, bus.D_md_stall}, 32'd0);
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cancel, vecs[i].d_use, 1'b0,
             '{vecs[i].hi, vecs[i].lo, vecs[i].cyc}, $sformatf("vec%0d", i));
    run_op(OP_MTHI, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, '{32'h12345678, 32'hFFFFFFF1, 0}, "mthi2");
    bus.E_md_op = OP_MFHI;
    #1 check("mfhi out", bus.E_md_out, 32'h12345678);
    bus.E_md_op = OP_MFLO;
    #1 check("mflo out", bus.E_md_out, 32'hFFFFFFF1);
    bus.E_md_op = OP_NONE;
    #1 check("none out", bus.E_md_out, 32'd0);
    bus.E_md_op = 4'd12;
    #1 check("op12 out", bus.E_md_out, 32'd0);
    @(negedge clk);
    bus.D_md_use = 1'b1;
    bus.E_start  = 1'b1;
    bus.E_cancel = 1'b1;
    bus.E_md_op  = OP_MULT;
    #1 check("stall mult idle", {31'd0, bus.D_md_stall}, 32'd1);
    bus.E_md_op = OP_MTHI;
    #1 check("stall mthi idle", {31'd0, bus.D_md_stall}, 32'd0);
    bus.E_md_op = OP_DIVU;
    #1 check("stall divu idle", {31'd0, bus.D_md_stall}, 32'd1);
    bus.D_md_use = 1'b0;
    #1 check("stall no use", {31'd0, bus.D_md_stall}, 32'd0);
    @(negedge clk);
    check("cancel no busy", {31'd0, bus.busy}, 32'd0);
    bus.E_start  = 1'b0;
    bus.E_cancel = 1'b0;
    @(negedge clk);
    bus.E_start  = 1'b1;
    bus.E_md_op  = OP_DIV;
    bus.E_rs_val = 32'd100;
    bus.E_rt_val = 32'd3;
    @(negedge clk);
    bus.E_start = 1'b0;
    repeat (2) @(negedge clk);
    reset        = 1'b1;
    bus.E_start  = 1'b1;
    bus.E_md_op  = OP_MTHI;
    bus.E_rs_val = 32'h0000ABCD;
    @(negedge clk);
    reset       = 1'b0;
    bus.E_start = 1'b0;
    bus.E_md_op = OP_NONE;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    repeat (12) @(negedge clk);
    check("late hi", bus.hi, 32'd0);
    check("late lo", bus.lo, 32'd0);
    check("late busy", {31'd0, bus.busy}, 32'd0);
    run_op(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1, '{32'd0, 32'd42, 5}, "relaunch");
    @(negedge clk);
    check("relaunch idle", {31'd0, bus.busy}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port E_start, input, 1 bit: the E-stage instruction is a mult/div/HI-LO instruction.
REQ-004 SHALL have port E_md_op, input, 4 bits: operation code, defined in REQ-019.
REQ-005 SHALL have port E_rs_val, input, 32 bits: first operand, forwarded rs value.
REQ-006 SHALL have port E_rt_val, input, 32 bits: second operand, forwarded rt value.
REQ-007 SHALL have port E_cancel, input, 1 bit: exception/interrupt flush of the E-stage instruction.
REQ-008 SHALL have port D_md_use, input, 1 bit: the D-stage instruction is any mult/div/HI-LO instruction.
REQ-009 SHALL have port busy, output, 1 bit: a multi-cycle operation is in flight.
REQ-010 SHALL have port D_md_stall, output, 1 bit: stall request to the decode stage.
REQ-011 SHALL have port E_md_out, output, 32 bits: mfhi/mflo read data.
REQ-012 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-013 SHALL have port lo, output, 32 bits: architectural LO register.

Function
REQ-014 SHALL define launch = E_start & !E_cancel & !busy; no operation or HI/LO write SHALL occur without launch.
REQ-015 SHALL implement two states, IDLE and BUSY: IDLE->BUSY on launch of MULT/MULTU/DIV/DIVU; BUSY->IDLE at the edge where the counter reaches 1.
REQ-016 SHALL, on launch, compute the result from the operands sampled that cycle, hold it in pending registers, and load a 4-bit counter with 5 (mult/multu) or 10 (div/divu).
REQ-017 SHALL assert busy for exactly 5 or 10 cycles, starting the cycle after launch, and SHALL update hi/lo at the same edge that drops busy.
REQ-018 SHALL ignore E_start while busy: no relaunch, and pending results stay intact. The pipeline stall prevents this case; the behaviour SHALL still be defined.
REQ-019 SHALL use this E_md_op encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO. Codes 9-15 SHALL be treated as NONE.
REQ-020 SHALL, for MULT/MULTU, produce the 64-bit signed/unsigned product, with hi = bits 63:32 and lo = bits 31:0.
REQ-021 SHALL, for DIV/DIVU, produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign (DIV) or unsigned (DIVU).
REQ-022 SHALL leave hi/lo unchanged for division by zero, while still running busy for 10 cycles.
REQ-023 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, give lo = 0x80000000 and hi = 0.
REQ-024 SHALL, on launch of MTHI/MTLO, write hi/lo from E_rs_val at the launch edge, with no busy cycles.
REQ-025 SHALL drive E_md_out combinationally: hi when E_md_op = MFHI, lo when E_md_op = MFLO, else 0.
REQ-026 SHALL drive D_md_stall = D_md_use & (busy | (E_start & E_md_op in 1..4)).
REQ-027 SHALL not abort an in-flight operation when E_cancel is asserted during BUSY.

Reset
REQ-028 SHALL, when reset is high at an edge, force state to IDLE, counter to 0, busy to 0, hi/lo to 0x00000000 and pending registers to 0, overriding launch in that cycle.
REQ-029 SHALL, if reset occurs mid-operation, discard the result and not update hi/lo after reset.

Structure
REQ-030 SHALL place the md_op codes, the state encoding and MULT_CYC=5 / DIV_CYC=10 in a shared package used with the decode controller.
REQ-031 SHALL isolate the arithmetic in one sub-module, md_arith (combinational product/quotient/remainder); sequencing SHALL remain in mdu_ctrl.

Verification
REQ-032 SHALL cover: MULT 0xFFFFFFFF x 0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; D_md_use=1 during busy -> D_md_stall=1 for 5 cycles.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 / 0x00000002 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged.
REQ-035 SHALL cover: MTHI 0x12345678 with E_cancel=1 -> hi unchanged and busy=0; repeated with E_cancel=0 -> hi=0x12345678 at the next edge; MFHI -> E_md_out=0x12345678.
REQ-036 SHALL cover: reset at cycle 3 of a DIV -> busy=0 and hi=lo=0 next cycle, and no late update.
REQ-037 SHALL cover: E_start with MULT while busy -> ignored, and the original result commits on schedule.
